// File: rtl/spi_slave_gen.sv
// spi_slave_gen -- SPI slave front-end for the SPI-wrapper RAM path.
//
// Deserialises MOSI command frames of FRAME_W = DATA_W+2 bits ({cmd[1:0], payload})
// and presents each complete frame on rx_data with a one-cycle rx_valid strobe.
// For a read-data frame (a read command while a read address is pending), the block
// waits for tx_valid, captures tx_data and shifts it out on MISO, MSB first.
//
// Parameters:
//   DATA_W      payload width (min 4); frame width is DATA_W+2
//   TX_TIMEOUT  max cycles to wait for tx_valid after the read-data frame; 0 = forever
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   SS_n        slave select, active low
//   MOSI        serial in, MSB first
//   tx_valid    tx_data valid from the RAM
//   tx_data     read data from the RAM
//   MISO        serial out, MSB first
//   rx_valid    one-cycle strobe, rx_data holds a complete frame
//   rx_data     {cmd[1:0], payload}; 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   frame_err   one-cycle strobe on an aborted frame or a tx_valid timeout
//
// Optional feature macro: SPI_SLV_FRAME_ERR_EN. When undefined, frame_err is tied to 0
// and no error-detection logic exists.
//
// Handshake: tx_valid is only looked at while waiting in READ_DATA after the frame
// completed; the first tx_valid seen in that window is accepted, all others are ignored.

module spi_slave_gen #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              frame_err
);

    localparam int   FRAME_W      = DATA_W + 2;
    localparam int   CNT_W        = $clog2(FRAME_W + 1);
    localparam int   TXC_W        = $clog2(DATA_W);
    localparam int   WAIT_W       = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam int   TIMEOUT_LAST = (TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0;
    localparam logic TIMEOUT_EN   = (TX_TIMEOUT > 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Sub-phase of READ_DATA once the frame itself has been received.
    typedef enum logic [1:0] {
        RD_WAIT  = 2'd0,
        RD_SHIFT = 2'd1,
        RD_HOLD  = 2'd2
    } rd_phase_t;

    state_t             cs_q, ns;
    rd_phase_t          rd_phase_q, rd_phase_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               miso_q, miso_d;
    logic               rd_addr_pend_q, rd_addr_pend_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;

    logic frame_done;
    logic timeout_hit;

    assign frame_done  = (counter_q == CNT_W'(FRAME_W));

    // Last wait cycle expired with no tx_valid; SS_n rising takes priority.
    assign timeout_hit = TIMEOUT_EN && (cs_q == READ_DATA) && !SS_n && frame_done &&
                         (rd_phase_q == RD_WAIT) && !tx_valid &&
                         (wait_cnt_q == WAIT_W'(TIMEOUT_LAST));

    always_comb begin
        ns             = cs_q;
        rd_phase_d     = rd_phase_q;
        counter_d      = counter_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = miso_q;
        rd_addr_pend_d = rd_addr_pend_q;
        wait_cnt_d     = wait_cnt_q;
        tx_sh_d        = tx_sh_q;
        tx_cnt_d       = tx_cnt_q;

        case (cs_q)
            IDLE: begin
                if (!SS_n) ns = CHK_CMD;
            end
            CHK_CMD: begin
                // The command-select bit steers the state only; it is not shifted in.
                if (SS_n)                ns = IDLE;
                else if (!MOSI)          ns = WRITE;
                else if (!rd_addr_pend_q) ns = READ_ADD;
                else                     ns = READ_DATA;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    // Deselect: drop everything in flight; rx_data keeps its last value.
                    ns         = IDLE;
                    counter_d  = '0;
                    rd_phase_d = RD_WAIT;
                    wait_cnt_d = '0;
                    tx_sh_d    = '0;
                    tx_cnt_d   = '0;
                    miso_d     = 1'b0;
                end else if (!frame_done) begin
                    rx_data_d = {rx_data_q[FRAME_W-2:0], MOSI};
                    counter_d = counter_q + CNT_W'(1);
                    if (counter_q == CNT_W'(FRAME_W - 1)) begin
                        rx_valid_d = 1'b1;
                        if (cs_q == READ_ADD)  rd_addr_pend_d = 1'b1;
                        if (cs_q == READ_DATA) rd_addr_pend_d = 1'b0;
                    end
                end else if (cs_q == READ_DATA) begin
                    case (rd_phase_q)
                        RD_WAIT: begin
                            if (tx_valid) begin
                                miso_d     = tx_data[DATA_W-1];
                                tx_sh_d    = {tx_data[DATA_W-2:0], 1'b0};
                                tx_cnt_d   = TXC_W'(DATA_W - 1);
                                rd_phase_d = RD_SHIFT;
                            end else if (timeout_hit) begin
                                rd_phase_d = RD_HOLD;
                            end else if (TIMEOUT_EN) begin
                                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                            end
                        end
                        RD_SHIFT: begin
                            if (tx_cnt_q != '0) begin
                                miso_d   = tx_sh_q[DATA_W-1];
                                tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                                tx_cnt_d = tx_cnt_q - TXC_W'(1);
                            end else begin
                                miso_d     = 1'b0;
                                rd_phase_d = RD_HOLD;
                            end
                        end
                        default: miso_d = 1'b0;
                    endcase
                end
            end
            default: ns = IDLE;
        endcase
    end

`ifdef SPI_SLV_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;
    logic abort_hit;

    // A partial frame is one with at least one bit shifted but not all of them.
    assign abort_hit   = (cs_q != IDLE) && SS_n && (counter_q != '0) && !frame_done;
    assign frame_err_d = abort_hit || timeout_hit;
    assign frame_err   = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q           <= IDLE;
            rd_phase_q     <= RD_WAIT;
            counter_q      <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_pend_q <= 1'b0;
            wait_cnt_q     <= '0;
            tx_sh_q        <= '0;
            tx_cnt_q       <= '0;
`ifdef SPI_SLV_FRAME_ERR_EN
            frame_err_q    <= 1'b0;
`endif
        end else begin
            cs_q           <= ns;
            rd_phase_q     <= rd_phase_d;
            counter_q      <= counter_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_pend_q <= rd_addr_pend_d;
            wait_cnt_q     <= wait_cnt_d;
            tx_sh_q        <= tx_sh_d;
            tx_cnt_q       <= tx_cnt_d;
`ifdef SPI_SLV_FRAME_ERR_EN
            frame_err_q    <= frame_err_d;
`endif
        end
    end

    assign MISO     = miso_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
`timescale 1ns/1ps
module tb_spi_slave_gen;

    localparam int DATA_W     = 8;
    localparam int TX_TIMEOUT = 16;
    localparam int FRAME_W    = DATA_W + 2;
    localparam int W          = FRAME_W + 3;   // {rx_valid, rx_data, MISO, frame_err}
    localparam int MAXL       = 64;
    localparam int E_EDGE     = 1 + FRAME_W;   // edge index that completes a frame
    localparam int LOG_N      = 4096;
`ifdef SPI_SLV_FRAME_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               rst_n;
    logic               SS_n;
    logic               MOSI;
    logic               tx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               MISO;
    logic               rx_valid;
    logic [FRAME_W-1:0] rx_data;
    logic               frame_err;

    always #5 clk = ~clk;

    spi_slave_gen #(.DATA_W(DATA_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .tx_valid(tx_valid), .tx_data(tx_data), .MISO(MISO),
        .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_log[LOG_N];
    int           n_pop  = 0;
    int           n_push = 0;
    int           total  = 0;
    int           bad    = 0;
    logic         m_pend;  // model: a read address is pending

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One compare per cycle; rx_data only matters while rx_valid is expected.
    initial begin : compare
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {rx_valid, rx_data, MISO, frame_err};
                if (n_pop < LOG_N) act_log[n_pop] = a;
                total++;
                if (a[W-1] !== e[W-1] || a[1:0] !== e[1:0] ||
                    (e[W-1] && a[W-2:2] !== e[W-2:2])) begin
                    bad++;
                    $display("FAIL cycle_check idx=%0d actual=%h expected=%h", n_pop, a, e);
                end
                n_pop++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver + behavioural model ----------------
    // One SS_n-low session of `len` edges (edge 0 samples SS_n low in IDLE, edge `len`
    // samples SS_n high), then `gap` idle edges. Expected outputs after every edge are
    // derived from edge positions: data bits occupy edges 2..len-1, a full frame lands
    // at edge 1+FRAME_W, the tx window is the TX_TIMEOUT edges after that.
    task automatic session(input logic cmd, input logic [FRAME_W-1:0] frame, input int len,
                           input int tx_at, input logic [DATA_W-1:0] tx_val, input int noise,
                           input int gap, input int rst_at, output int base);
        logic [W-1:0]      ev[MAXL];
        logic              txv_a[MAXL];
        logic [DATA_W-1:0] txd_a[MAXL];
        int                ndata;
        int                last;
        int                c_edge;
        logic              rd_mode;
        base = n_push;
        for (int k = 0; k < MAXL; k++) begin
            ev[k]    = '0;
            txv_a[k] = (k == tx_at) || ($urandom_range(0, 99) < noise);
            txd_a[k] = (k == tx_at) ? tx_val : DATA_W'($urandom);
        end
        ndata   = (len > 2) ? len - 2 : 0;
        rd_mode = cmd && m_pend;
        if (ndata >= FRAME_W) begin
            ev[E_EDGE][W-1]   = 1'b1;
            ev[E_EDGE][W-2:2] = frame;
            if (rd_mode) begin
                last = (TX_TIMEOUT > 0) ? E_EDGE + TX_TIMEOUT : MAXL;
                if (last > len - 1) last = len - 1;
                c_edge = -1;
                for (int k = E_EDGE + 1; k <= last; k++)
                    if (c_edge < 0 && txv_a[k]) c_edge = k;
                if (c_edge >= 0) begin
                    for (int j = 0; j < DATA_W; j++)
                        if (c_edge + j < len) ev[c_edge+j][1] = txd_a[c_edge][DATA_W-1-j];
                end else if (TX_TIMEOUT > 0 && E_EDGE + TX_TIMEOUT < len) begin
                    ev[E_EDGE+TX_TIMEOUT][0] = ERR_EN;
                end
                m_pend = 1'b0;
            end else if (cmd) begin
                m_pend = 1'b1;
            end
        end else if (ndata > 0) begin
            ev[len][0] = ERR_EN;
        end

        for (int k = 0; k <= len + gap; k++) begin
            SS_n     = (k < len) ? 1'b0 : 1'b1;
            if (k == 1)                          MOSI = cmd;
            else if (k >= 2 && k < 2 + FRAME_W)  MOSI = frame[FRAME_W-1-(k-2)];
            else                                 MOSI = 1'($urandom);
            tx_valid = txv_a[k];
            tx_data  = txd_a[k];
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_rx_valid", 32'(rx_valid), 32'd0);
                check("rst_miso", 32'(MISO), 32'd0);
                check("rst_frame_err", 32'(frame_err), 32'd0);
                check("rst_cs", 32'(dut.cs_q), 32'd0);
                check("rst_pend", 32'(dut.rd_addr_pend_q), 32'd0);
                m_pend = 1'b0;
                @(posedge clk);
                exp_q.push_back('0);
                n_push++;
                @(negedge clk);
                #2 rst_n = 1'b1;
                SS_n = 1'b1;
                return;
            end
            @(posedge clk);
            exp_q.push_back((k <= len) ? ev[k] : '0);
            n_push++;
            @(negedge clk);
        end
    endtask

    function automatic logic [DATA_W-1:0] miso_byte(input int b0);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int j = 0; j < DATA_W; j++) r = {r[DATA_W-2:0], act_log[b0+j][1]};
        return r;
    endfunction

    function automatic int miso_ones(input int b0, input int n);
        int s;
        s = 0;
        for (int j = 0; j < n; j++) s += int'(act_log[b0+j][1]);
        return s;
    endfunction

    function automatic int rxv_count(input int b0, input int n);
        int s;
        s = 0;
        for (int j = 0; j < n; j++) s += int'(act_log[b0+j][W-1]);
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : main
        int b;
        int r;
        int len;
        int tx_at;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        m_pend = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_pend", 32'(dut.rd_addr_pend_q), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // wr-addr frame 00_1010_0101 with two trailing extra bits
        session(1'b0, 10'h0A5, 14, -1, '0, 0, 2, -1, b);
        check("wr_addr_rx_valid", 32'(act_log[b+11][W-1]), 32'd1);
        check("wr_addr_rx_data", 32'(act_log[b+11][W-2:2]), 32'h0A5);
        check("wr_addr_one_strobe", 32'(rxv_count(b, 17)), 32'd1);
        check("wr_addr_miso_quiet", 32'(miso_ones(b, 17)), 32'd0);

        // rd-addr then rd-data, tx_data C3 three edges after the frame
        session(1'b1, 10'h230, 12, -1, '0, 0, 1, -1, b);
        check("rd_addr_pend_set", 32'(dut.rd_addr_pend_q), 32'd1);
        session(1'b1, 10'h35A, 25, 14, 8'hC3, 0, 2, -1, b);
        check("rd_data_rx_data", 32'(act_log[b+11][W-2:2]), 32'h35A);
        check("rd_data_miso_byte", 32'(miso_byte(b + 14)), 32'hC3);
        check("rd_data_miso_after", 32'(act_log[b+22][1]), 32'd0);
        check("rd_data_pend_clr", 32'(dut.rd_addr_pend_q), 32'd0);

        // abort after 5 write bits
        session(1'b0, 10'h155, 7, -1, '0, 0, 2, -1, b);
        check("abort_frame_err", 32'(act_log[b+7][0]), 32'(ERR_EN));
        check("abort_no_rx_valid", 32'(rxv_count(b, 10)), 32'd0);

        // timeout: no tx_valid for the whole window
        session(1'b1, 10'h2FF, 12, -1, '0, 0, 0, -1, b);
        session(1'b1, 10'h300, 31, -1, '0, 0, 2, -1, b);
        check("timeout_err", 32'(act_log[b+27][0]), 32'(ERR_EN));
        check("timeout_err_early", 32'(act_log[b+26][0]), 32'd0);
        check("timeout_miso_quiet", 32'(miso_ones(b, 32)), 32'd0);

        // tx_valid on the last edge of the window is still accepted
        session(1'b1, 10'h2AA, 12, -1, '0, 0, 0, -1, b);
        session(1'b1, 10'h311, 40, 27, 8'h96, 0, 1, -1, b);
        check("window_edge_byte", 32'(miso_byte(b + 27)), 32'h96);
        check("window_edge_no_err", 32'(act_log[b+27][0]), 32'd0);

        // reset in the middle of a READ_DATA shift
        session(1'b1, 10'h2C0, 12, -1, '0, 0, 0, -1, b);
        session(1'b1, 10'h3C3, 30, 14, 8'hA5, 0, 0, 17, b);
        @(negedge clk);
        check("post_reset_pend", 32'(dut.rd_addr_pend_q), 32'd0);

        // randomized sessions
        for (int i = 0; i < 220; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0)      len = $urandom_range(1, FRAME_W + 1);
            else if (r == 1) len = $urandom_range(FRAME_W + 2, FRAME_W + 6);
            else             len = $urandom_range(FRAME_W + 2, E_EDGE + TX_TIMEOUT + DATA_W + 4);
            tx_at = ($urandom_range(0, 3) == 0) ? -1 :
                    int'($urandom_range(E_EDGE, E_EDGE + TX_TIMEOUT + 2));
            session(1'($urandom), FRAME_W'($urandom), len, tx_at, DATA_W'($urandom),
                    ($urandom_range(0, 1) == 1) ? 8 : 0, $urandom_range(0, 3),
                    ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len - 1)) : -1, b);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
